// File: rtl/dcu_mem_arb.sv
// Owns the DCU's single memory-interface port: picks one of four requesters,
// holds the grant for the whole transaction and steers BIU acks back to the owner.
module dcu_mem_arb #(
  parameter int BEATS_LINE = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nc_wr_req,
  input  logic       fill_req,
  input  logic       wb_req,
  input  logic       nc_rd_req,
  input  logic       normal_ack,
  input  logic       error_ack,
  output logic       mem_req,
  output logic [1:0] mem_type,
  output logic [3:0] gnt,
  output logic [2:0] beat_cnt,
  output logic [3:0] ack_normal,
  output logic [3:0] ack_error,
  output logic       arb_idle,
  output logic       spurious_ack,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_FILL = 2'b00;
  localparam logic [1:0] TYPE_WB   = 2'b01;
  localparam logic [1:0] TYPE_NCWR = 2'b10;
  localparam logic [1:0] TYPE_NCRD = 2'b11;

  localparam logic [2:0] LINE_LAST = 3'(BEATS_LINE - 1);
  localparam int         SW        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SC_MAX = SW'(STARVE_MAX);

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    mem_type_q, mem_type_d;
  logic [2:0]    beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          arb_idle_q, arb_idle_d;

  logic [3:0]    win;
  logic [1:0]    win_type;
  logic [2:0]    last_beat;
  logic          in_xfer;

  // Fixed priority nc_wr > fill > wb > nc_rd, except a starved wb jumps ahead of fill.
  always_comb begin
    win      = 4'b0000;
    win_type = TYPE_FILL;
    if (nc_wr_req) begin
      win      = 4'b0001;
      win_type = TYPE_NCWR;
    end else if (wb_req && (starve_cnt_q == SC_MAX)) begin
      win      = 4'b0100;
      win_type = TYPE_WB;
    end else if (fill_req) begin
      win      = 4'b0010;
      win_type = TYPE_FILL;
    end else if (wb_req) begin
      win      = 4'b0100;
      win_type = TYPE_WB;
    end else if (nc_rd_req) begin
      win      = 4'b1000;
      win_type = TYPE_NCRD;
    end
  end

  assign last_beat = ((mem_type_q == TYPE_FILL) || (mem_type_q == TYPE_WB)) ? LINE_LAST : 3'd0;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    mem_type_d   = mem_type_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    arb_idle_d   = arb_idle_q;
    case (state_q)
      ST_IDLE: begin
        if (win != 4'b0000) begin
          state_d    = ST_XFER;
          gnt_d      = win;
          mem_type_d = win_type;
          beat_cnt_d = 3'd0;
          mem_req_d  = 1'b1;
          arb_idle_d = 1'b0;
          if (win == 4'b0100) begin
            starve_cnt_d = '0;
          end else if ((win == 4'b0010) && wb_req && (starve_cnt_q != SC_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (error_ack) begin
          state_d    = ST_ERR;
          gnt_d      = 4'b0000;
          mem_type_d = TYPE_FILL;
          beat_cnt_d = 3'd0;
          mem_req_d  = 1'b0;
        end else if (normal_ack) begin
          if (beat_cnt_q == last_beat) begin
            state_d    = ST_IDLE;
            gnt_d      = 4'b0000;
            mem_type_d = TYPE_FILL;
            beat_cnt_d = 3'd0;
            mem_req_d  = 1'b0;
            arb_idle_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      ST_ERR: begin
        state_d    = ST_IDLE;
        arb_idle_d = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        gnt_d      = 4'b0000;
        mem_type_d = TYPE_FILL;
        beat_cnt_d = 3'd0;
        mem_req_d  = 1'b0;
        arb_idle_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 4'b0000;
      mem_type_q   <= TYPE_FILL;
      beat_cnt_q   <= 3'd0;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      arb_idle_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      mem_type_q   <= mem_type_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      arb_idle_q   <= arb_idle_d;
    end
  end

  // Acks are steered combinationally so the owner sees them in the BIU's cycle.
  assign in_xfer      = (state_q == ST_XFER);
  assign ack_error    = (in_xfer && error_ack) ? gnt_q : 4'b0000;
  assign ack_normal   = (in_xfer && normal_ack && !error_ack) ? gnt_q : 4'b0000;
  assign spurious_ack = !in_xfer && !reset && (normal_ack || error_ack);

  assign mem_req   = mem_req_q;
  assign mem_type  = mem_type_q;
  assign gnt       = gnt_q;
  assign beat_cnt  = beat_cnt_q;
  assign arb_idle  = arb_idle_q;
  assign state_dbg = state_q;

endmodule
